burst_load: RTL and testbench
=============================

// Module: burst_load
// PURPOSE
//  Read-direction counterpart of burst_store: accepts a load-burst (LDB) instruction and acts as AXI read master.
//  Issues one INCR read burst per enabled SMC and writes the returned beats into the unified register (UR) file.
//  Sits between the instruction issuer and an AXI read slave (memory model or slave bridge).
//  Drives the ur_model write port in place of the tied-off ur_we path.
// PARAMETERS
//  ADDR_WIDTH   32   AXI address width
//  DATA_WIDTH   128  AXI/UR data width; arsize = log2(DATA_WIDTH/8)
//  SMC_COUNT    6    number of SMCs, one bit each in ldb_u_smc_strb
//  UR_BYTE_CNT  16   UR byte-enable width (DATA_WIDTH/8)
//  INTLV_STEP   64   byte offset between SMC address windows
// PORTS
//  clk                 in   1            clock
//  rst                 in   1            asynchronous reset, active-high
//  ldb_u_valid         in   1            instruction valid
//  ldb_u_ready         out  1            instruction accepted when valid&ready
//  ldb_u_smc_strb      in   SMC_COUNT    SMC enable mask
//  ldb_u_byte_strb     in   4            byte-enable code
//  ldb_u_brst          in   2            burst-length code
//  ldb_u_gr_base_addr  in   ADDR_WIDTH   external memory base address
//  ldb_u_ur_id         in   4            target UR id
//  ldb_u_ur_addr       in   11           first UR address
//  ldb_d_valid         out  1            completion status valid
//  ldb_d_ready         in   1            completion accepted
//  ldb_d_done          out  1            one-cycle pulse on completion handshake
//  ldb_d_err           out  1            sticky error for this instruction; valid with ldb_d_valid
//  axi_arvalid/arready out/in 1          AR handshake
//  axi_araddr          out  ADDR_WIDTH   read address
//  axi_arlen           out  8            beats-1
//  axi_arsize          out  3            log2(UR_BYTE_CNT)
//  axi_arburst         out  2            2'b01 (INCR)
//  axi_rvalid/rready   in/out 1          R handshake
//  axi_rdata           in   DATA_WIDTH   read data
//  axi_rresp           in   2            read response
//  axi_rlast           in   1            last beat of burst
//  ur_we               out  1            UR write strobe
//  ur_id               out  4            latched ldb_u_ur_id
//  ur_addr             out  11           UR write address
//  ur_wdata            out  DATA_WIDTH   UR write data
//  ur_wstrb            out  UR_BYTE_CNT  UR byte enables
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 except ldb_u_ready=1 and axi_arsize/arburst constants.
//  ldb_u_ready=(state==IDLE). Accepting latches all ldb_u_* fields; inputs are don't-care afterwards.
//  brst code: 00->1, 01->2, 10->4, 11->8 beats; axi_arlen=beats-1.
//  byte_strb code n: 0 -> all UR_BYTE_CNT bytes; 1..15 -> low n bytes set. Same ur_wstrb on every beat.
//  FSM IDLE->AR->R->(AR|DONE)->IDLE.
//   IDLE: on accept, pending mask=smc_strb. If mask==0 go to DONE (no AXI traffic), else go to AR.
//   AR: selects the lowest set pending bit i. araddr=gr_base_addr+i*INTLV_STEP (modulo 2^ADDR_WIDTH).
//       arvalid=1; all AR fields stay stable until arready; the handshake moves to R.
//   R: rready=1; each rvalid&rready increments beat_cnt. On beat_cnt==beats-1 clear bit i.
//      Go to AR if pending!=0, else DONE.
//   DONE: ldb_d_valid=1 until ldb_d_ready; the handshake pulses ldb_d_done and returns to IDLE.
//  Latency: accept at cycle T -> arvalid at T+1; AR handshake at cycle A -> rready at A+1.
//  UR write is registered: an R beat at cycle B gives ur_we=1 at B+1 with ur_wdata=rdata(B).
//  The last ur_we coincides with the first DONE cycle.
//  ur_addr starts at ldb_u_ur_addr and increments by 1 per written beat, continuous across SMCs.
//  ur_addr wraps 11 bits: 0x7FF->0x000.
//  The beat counter alone ends a burst. rlast missing on the expected last beat, or asserted early:
//   set ldb_d_err, continue counting.
//  rresp!=OKAY: still write the beat, set ldb_d_err. ldb_d_err clears on the next accept.
//  rst mid-operation: immediate return to IDLE, outputs to reset values, in-flight burst abandoned.
// TESTING
//  smc=6'b000001, brst=00, base=0x1000, ur_addr=0x010
//   -> one AR araddr=0x1000 arlen=0; one ur_we @0x010 with rdata; ldb_d_done; err=0.
//  smc=6'b100101, brst=10, base=0x2000
//   -> ARs 0x2000, 0x2080, 0x2140, arlen=3 each; 12 ur_we at consecutive ur_addr.
//  Random arready/rvalid stalls up to 5 cycles
//   -> AR fields stable while arvalid&!arready; ur_we count == R handshakes == 12; data in order.
//  rresp=2'b10 on beat 2 of 4
//   -> all 4 beats written; ldb_d_err=1 at ldb_d_valid; next instruction shows err=0.
//  ur_addr=0x7FE, brst=10, one SMC -> writes at 0x7FE, 0x7FF, 0x000, 0x001.
//  smc=0 -> no arvalid; ldb_d_valid at T+1. rst asserted mid-R -> IDLE, ldb_u_ready=1, no further ur_we.

Source files
------------

// File: rtl/burst_load.sv
// burst_load: takes one load-burst instruction and reads one INCR burst per enabled SMC
// over AXI, writing every returned beat into the UR file.
// Ports: instruction in (ldb_u_*), completion out (ldb_d_*), AXI AR/R master, UR write port.
// Latency: accept -> arvalid next cycle; R beat -> ur_we next cycle. Backpressure: arready/rvalid/ldb_d_ready stall the FSM.
module burst_load #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 128,
  parameter int SMC_COUNT   = 6,
  parameter int UR_BYTE_CNT = 16,
  parameter int INTLV_STEP  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ldb_u_valid,
  output logic                   ldb_u_ready,
  input  logic [SMC_COUNT-1:0]   ldb_u_smc_strb,
  input  logic [3:0]             ldb_u_byte_strb,
  input  logic [1:0]             ldb_u_brst,
  input  logic [ADDR_WIDTH-1:0]  ldb_u_gr_base_addr,
  input  logic [3:0]             ldb_u_ur_id,
  input  logic [10:0]            ldb_u_ur_addr,
  output logic                   ldb_d_valid,
  input  logic                   ldb_d_ready,
  output logic                   ldb_d_done,
  output logic                   ldb_d_err,
  output logic                   axi_arvalid,
  input  logic                   axi_arready,
  output logic [ADDR_WIDTH-1:0]  axi_araddr,
  output logic [7:0]             axi_arlen,
  output logic [2:0]             axi_arsize,
  output logic [1:0]             axi_arburst,
  input  logic                   axi_rvalid,
  output logic                   axi_rready,
  input  logic [DATA_WIDTH-1:0]  axi_rdata,
  input  logic [1:0]             axi_rresp,
  input  logic                   axi_rlast,
  output logic                   ur_we,
  output logic [3:0]             ur_id,
  output logic [10:0]            ur_addr,
  output logic [DATA_WIDTH-1:0]  ur_wdata,
  output logic [UR_BYTE_CNT-1:0] ur_wstrb
);

  localparam int IDX_W = (SMC_COUNT > 1) ? $clog2(SMC_COUNT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [SMC_COUNT-1:0]    pend_q, pend_d;
  logic [1:0]              brst_q, brst_d;
  logic [3:0]              bstrb_q, bstrb_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [3:0]              id_q, id_d;
  logic [10:0]             wptr_q, wptr_d;   // address of the next beat to be written
  logic [2:0]              beat_q, beat_d;
  logic                    err_q, err_d;
  logic                    we_q, we_d;
  logic [10:0]             waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [UR_BYTE_CNT-1:0]  wstrb_q, wstrb_d;

  logic [2:0]              last_beat;
  logic [IDX_W-1:0]        idx;
  logic [UR_BYTE_CNT-1:0]  strb_mask;
  logic [SMC_COUNT-1:0]    pend_clr;

  always_comb begin
    case (brst_q)
      2'd0:    last_beat = 3'd0;
      2'd1:    last_beat = 3'd1;
      2'd2:    last_beat = 3'd3;
      default: last_beat = 3'd7;
    endcase
  end

  // Lowest pending SMC. Pending only changes on the last beat of a burst,
  // so the same index drives both the AR fields and the bit cleared in R.
  always_comb begin
    idx = '0;
    for (int i = SMC_COUNT - 1; i >= 0; i--) begin
      if (pend_q[i]) idx = IDX_W'(i);
    end
  end

  // Byte-enable code 0 means the full UR word; otherwise the low n bytes.
  always_comb begin
    strb_mask = '0;
    for (int b = 0; b < UR_BYTE_CNT; b++) begin
      strb_mask[b] = (bstrb_q == 4'd0) || (b < int'(bstrb_q));
    end
  end

  assign pend_clr = pend_q & ~(SMC_COUNT'(1) << idx);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    brst_d  = brst_q;
    bstrb_d = bstrb_q;
    base_d  = base_q;
    id_d    = id_q;
    wptr_d  = wptr_q;
    beat_d  = beat_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (ldb_u_valid) begin
          pend_d  = ldb_u_smc_strb;
          brst_d  = ldb_u_brst;
          bstrb_d = ldb_u_byte_strb;
          base_d  = ldb_u_gr_base_addr;
          id_d    = ldb_u_ur_id;
          wptr_d  = ldb_u_ur_addr;
          beat_d  = 3'd0;
          err_d   = 1'b0;
          state_d = (ldb_u_smc_strb == '0) ? S_DONE : S_AR;
        end
      end
      S_AR: begin
        if (axi_arready) begin
          beat_d  = 3'd0;
          state_d = S_R;
        end
      end
      S_R: begin
        if (axi_rvalid) begin
          we_d    = 1'b1;
          waddr_d = wptr_q;
          wptr_d  = wptr_q + 11'd1;
          wdata_d = axi_rdata;
          wstrb_d = strb_mask;
          // Only the local beat count ends a burst; a misplaced rlast is just flagged.
          if (axi_rresp != 2'b00) err_d = 1'b1;
          if (axi_rlast != (beat_q == last_beat)) err_d = 1'b1;
          if (beat_q == last_beat) begin
            pend_d  = pend_clr;
            state_d = (pend_clr != '0) ? S_AR : S_DONE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      S_DONE: begin
        if (ldb_d_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      brst_q  <= '0;
      bstrb_q <= '0;
      base_q  <= '0;
      id_q    <= '0;
      wptr_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      brst_q  <= brst_d;
      bstrb_q <= bstrb_d;
      base_q  <= base_d;
      id_q    <= id_d;
      wptr_q  <= wptr_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign ldb_u_ready = (state_q == S_IDLE);
  assign ldb_d_valid = (state_q == S_DONE);
  assign ldb_d_done  = (state_q == S_DONE) && ldb_d_ready;
  assign ldb_d_err   = err_q;
  assign axi_arvalid = (state_q == S_AR);
  assign axi_araddr  = (state_q == S_AR)
                       ? base_q + ADDR_WIDTH'(idx) * ADDR_WIDTH'(INTLV_STEP)
                       : '0;
  assign axi_arlen   = {5'd0, last_beat};
  assign axi_arsize  = 3'($clog2(UR_BYTE_CNT));
  assign axi_arburst = 2'b01;
  assign axi_rready  = (state_q == S_R);
  assign ur_we       = we_q;
  assign ur_id       = id_q;
  assign ur_addr     = waddr_q;
  assign ur_wdata    = wdata_q;
  assign ur_wstrb    = wstrb_q;

endmodule

// File: tb/tb_burst_load.sv
module tb_burst_load;

  logic         clk = 1'b0;
  logic         rst;
  logic         ldb_u_valid, ldb_u_ready;
  logic [5:0]   ldb_u_smc_strb;
  logic [3:0]   ldb_u_byte_strb;
  logic [1:0]   ldb_u_brst;
  logic [31:0]  ldb_u_gr_base_addr;
  logic [3:0]   ldb_u_ur_id;
  logic [10:0]  ldb_u_ur_addr;
  logic         ldb_d_valid, ldb_d_ready, ldb_d_done, ldb_d_err;
  logic         axi_arvalid, axi_arready;
  logic [31:0]  axi_araddr;
  logic [7:0]   axi_arlen;
  logic [2:0]   axi_arsize;
  logic [1:0]   axi_arburst;
  logic         axi_rvalid, axi_rready;
  logic [127:0] axi_rdata;
  logic [1:0]   axi_rresp;
  logic         axi_rlast;
  logic         ur_we;
  logic [3:0]   ur_id;
  logic [10:0]  ur_addr;
  logic [127:0] ur_wdata;
  logic [15:0]  ur_wstrb;

  always #5 clk = ~clk;

  burst_load dut (
    .clk(clk), .rst(rst),
    .ldb_u_valid(ldb_u_valid), .ldb_u_ready(ldb_u_ready),
    .ldb_u_smc_strb(ldb_u_smc_strb), .ldb_u_byte_strb(ldb_u_byte_strb),
    .ldb_u_brst(ldb_u_brst), .ldb_u_gr_base_addr(ldb_u_gr_base_addr),
    .ldb_u_ur_id(ldb_u_ur_id), .ldb_u_ur_addr(ldb_u_ur_addr),
    .ldb_d_valid(ldb_d_valid), .ldb_d_ready(ldb_d_ready),
    .ldb_d_done(ldb_d_done), .ldb_d_err(ldb_d_err),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .ur_we(ur_we), .ur_id(ur_id), .ur_addr(ur_addr),
    .ur_wdata(ur_wdata), .ur_wstrb(ur_wstrb)
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [10:0] addr; logic [15:0] strb; logic [3:0] id; } ur_t;
  typedef struct packed { logic err; logic beats; } dn_t;

  ar_t          ar_exp[$];
  ur_t          ur_exp[$];
  dn_t          dn_exp[$];
  logic [127:0] dq[$];
  logic [1:0]   resp_cfg[$];
  logic         flip_cfg[$];

  int checks = 0;
  int passed = 0;
  int ur_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: got event, expected none / timely event", name);
  endtask

  task automatic summary_and_end();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_stall = 1'b0, prev_r_hs = 1'b0, prev_dv = 1'b0;
  logic [31:0] held_addr;
  logic [7:0]  held_len;

  always @(negedge clk) begin
    if (rst) begin
      ar_exp.delete(); ur_exp.delete(); dn_exp.delete(); dq.delete();
      resp_cfg.delete(); flip_cfg.delete();
      prev_stall = 1'b0; prev_r_hs = 1'b0; prev_dv = 1'b0;
    end else begin
      if (ur_we || prev_r_hs) chk("ur_we_latency", ur_we, prev_r_hs);
      if (ur_we) begin
        ur_cnt++;
        if (ur_exp.size() == 0 || dq.size() == 0) fail("ur_we_unexpected");
        else begin
          ur_t e;
          logic [127:0] d;
          e = ur_exp.pop_front();
          d = dq.pop_front();
          chk("ur_addr", ur_addr, e.addr);
          chk("ur_wstrb", ur_wstrb, e.strb);
          chk("ur_id", ur_id, e.id);
          chk("ur_wdata", ur_wdata, d);
        end
      end
      if (prev_stall && !axi_arvalid) fail("arvalid_dropped");
      if (axi_arvalid) begin
        if (prev_stall) begin
          chk("ar_stable_addr", axi_araddr, held_addr);
          chk("ar_stable_len", axi_arlen, held_len);
        end
        if (axi_arready) begin
          if (ar_exp.size() == 0) fail("ar_unexpected");
          else begin
            ar_t a;
            a = ar_exp.pop_front();
            chk("araddr", axi_araddr, a.addr);
            chk("arlen", axi_arlen, a.len);
            chk("arsize", axi_arsize, 3'd4);
            chk("arburst", axi_arburst, 2'b01);
          end
        end
      end
      prev_stall = axi_arvalid && !axi_arready;
      held_addr  = axi_araddr;
      held_len   = axi_arlen;
      if (ldb_d_valid && !prev_dv && dn_exp.size() > 0 && dn_exp[0].beats)
        chk("last_we_at_done", ur_we, 1'b1);
      if (ldb_d_done || (ldb_d_valid && ldb_d_ready))
        chk("done_pulse", ldb_d_done, ldb_d_valid && ldb_d_ready);
      if (ldb_d_valid && ldb_d_ready) begin
        if (dn_exp.size() == 0) fail("done_unexpected");
        else begin
          dn_t dn;
          dn = dn_exp.pop_front();
          chk("ldb_d_err", ldb_d_err, dn.err);
        end
      end
      prev_dv   = ldb_d_valid && !ldb_d_ready;
      prev_r_hs = axi_rvalid && axi_rready;
    end
  end

  // ---------------- AXI read slave with random stalls ----------------
  initial begin
    logic [7:0] bursts[$];
    int   cur_beat;
    logic ar_hs, r_hs, rs, fl;
    logic [7:0] len_s;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00; axi_rlast = 1'b0;
    cur_beat = 0;
    forever begin
      @(negedge clk);
      ar_hs = axi_arvalid && axi_arready;
      r_hs  = axi_rvalid && axi_rready;
      len_s = axi_arlen;
      rs    = rst;
      @(posedge clk);
      #1;
      if (rs || rst) begin
        bursts.delete(); cur_beat = 0;
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00;
        continue;
      end
      if (ar_hs) bursts.push_back(len_s);
      if (r_hs) begin
        dq.push_back(axi_rdata);
        if (cur_beat == int'(bursts[0])) begin
          void'(bursts.pop_front());
          cur_beat = 0;
        end else cur_beat++;
      end
      axi_arready = ($urandom_range(0, 2) != 0);
      if (axi_rvalid && !r_hs) begin
        // hold the presented beat until it is taken
      end else if (bursts.size() > 0 && $urandom_range(0, 3) != 0) begin
        axi_rvalid = 1'b1;
        axi_rdata  = {$urandom, $urandom, $urandom, $urandom};
        axi_rresp  = (resp_cfg.size() > 0) ? resp_cfg.pop_front() : 2'b00;
        fl         = (flip_cfg.size() > 0) ? flip_cfg.pop_front() : 1'b0;
        axi_rlast  = (cur_beat == int'(bursts[0])) ^ fl;
      end else begin
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
      end
    end
  end

  initial begin
    ldb_d_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ldb_d_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- reference model + driver ----------------
  task automatic issue(input logic [5:0] smc, input logic [1:0] brst, input logic [3:0] bs,
                       input logic [31:0] base, input logic [3:0] id, input logic [10:0] ua,
                       input int err_beat, input bit rnd_err);
    int beats, gb;
    logic [10:0] a;
    logic [15:0] mask;
    logic err;
    ar_t ae;
    ur_t ue;
    dn_t de;
    beats = 1 << brst;
    mask  = (bs == 4'd0) ? 16'hFFFF : 16'((1 << bs) - 1);
    a = ua; err = 1'b0; gb = 0;
    for (int i = 0; i < 6; i++) begin
      if (smc[i]) begin
        ae.addr = base + 32'(i * 64);
        ae.len  = 8'(beats - 1);
        ar_exp.push_back(ae);
        for (int b = 0; b < beats; b++) begin
          logic [1:0] r;
          logic f;
          ue.addr = a; ue.strb = mask; ue.id = id;
          ur_exp.push_back(ue);
          a = a + 11'd1;
          r = (gb == err_beat || (rnd_err && $urandom_range(0, 15) == 0)) ? 2'b10 : 2'b00;
          f = rnd_err && ($urandom_range(0, 15) == 0);
          resp_cfg.push_back(r);
          flip_cfg.push_back(f);
          err = err | (r != 2'b00) | f;
          gb++;
        end
      end
    end
    de.err = err; de.beats = (smc != 6'd0);
    dn_exp.push_back(de);

    @(posedge clk);
    #1;
    ldb_u_valid = 1'b1; ldb_u_smc_strb = smc; ldb_u_brst = brst; ldb_u_byte_strb = bs;
    ldb_u_gr_base_addr = base; ldb_u_ur_id = id; ldb_u_ur_addr = ua;
    begin : wait_rdy
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (ldb_u_ready) disable wait_rdy;
      end
      fail("accept_timeout");
      summary_and_end();
    end
    @(posedge clk);
    #1;
    ldb_u_valid = 1'b0;
    ldb_u_smc_strb = 6'($urandom); ldb_u_brst = 2'($urandom); ldb_u_byte_strb = 4'($urandom);
    ldb_u_gr_base_addr = $urandom; ldb_u_ur_id = 4'($urandom); ldb_u_ur_addr = 11'($urandom);
    @(negedge clk);
    chk("arvalid_at_T+1", axi_arvalid, smc != 6'd0);
    chk("d_valid_at_T+1", ldb_d_valid, smc == 6'd0);
  endtask

  task automatic wait_done();
    begin : wd
      for (int n = 0; n < 3000; n++) begin
        @(negedge clk);
        if (dn_exp.size() == 0) disable wd;
      end
      fail("completion_timeout");
      summary_and_end();
    end
    chk("ar_left", ar_exp.size(), 0);
    chk("ur_left", ur_exp.size(), 0);
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    ldb_u_valid = 1'b0; ldb_u_smc_strb = '0; ldb_u_brst = '0; ldb_u_byte_strb = '0;
    ldb_u_gr_base_addr = '0; ldb_u_ur_id = '0; ldb_u_ur_addr = '0;
    @(negedge clk);
    chk("rst_u_ready", ldb_u_ready, 1'b1);
    chk("rst_d_valid", ldb_d_valid, 1'b0);
    chk("rst_d_done", ldb_d_done, 1'b0);
    chk("rst_d_err", ldb_d_err, 1'b0);
    chk("rst_arvalid", axi_arvalid, 1'b0);
    chk("rst_araddr", axi_araddr, 32'd0);
    chk("rst_arlen", axi_arlen, 8'd0);
    chk("rst_arsize", axi_arsize, 3'd4);
    chk("rst_arburst", axi_arburst, 2'b01);
    chk("rst_rready", axi_rready, 1'b0);
    chk("rst_ur_we", ur_we, 1'b0);
    chk("rst_ur_addr", ur_addr, 11'd0);
    chk("rst_ur_wstrb", ur_wstrb, 16'd0);
    chk("rst_ur_wdata", ur_wdata, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(6'b000001, 2'b00, 4'd0, 32'h1000, 4'd3, 11'h010, -1, 1'b0);
    wait_done();

    c0 = ur_cnt;
    issue(6'b100101, 2'b10, 4'd5, 32'h2000, 4'd7, 11'h100, -1, 1'b0);
    wait_done();
    chk("ur_we_count_12", ur_cnt - c0, 12);

    issue(6'b000010, 2'b10, 4'd0, 32'h3000, 4'd1, 11'h040, 1, 1'b0);
    wait_done();
    issue(6'b000010, 2'b10, 4'd8, 32'h3000, 4'd1, 11'h050, -1, 1'b0);
    wait_done();

    issue(6'b001000, 2'b10, 4'd15, 32'h4000, 4'd9, 11'h7FE, -1, 1'b0);
    wait_done();

    issue(6'b000000, 2'b11, 4'd0, 32'h5000, 4'd2, 11'h000, -1, 1'b0);
    wait_done();

    issue(6'b110000, 2'b11, 4'd0, 32'hFFFF_FFC0, 4'd4, 11'h300, -1, 1'b0);
    wait_done();

    // Reset in the middle of a read burst.
    c0 = ur_cnt;
    issue(6'b000011, 2'b11, 4'd0, 32'h6000, 4'd6, 11'h200, -1, 1'b0);
    begin : wait_beat
      for (int n = 0; n < 300; n++) begin
        @(negedge clk);
        if (ur_cnt > c0 && axi_rready) disable wait_beat;
      end
      fail("mid_burst_timeout");
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_u_ready", ldb_u_ready, 1'b1);
    chk("midrst_ur_we", ur_we, 1'b0);
    chk("midrst_rready", axi_rready, 1'b0);
    chk("midrst_arvalid", axi_arvalid, 1'b0);
    chk("midrst_d_valid", ldb_d_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    c0 = ur_cnt;
    repeat (20) @(negedge clk);
    chk("no_we_after_rst", ur_cnt - c0, 0);
    chk("idle_after_rst", ldb_u_ready, 1'b1);

    for (int k = 0; k < 40; k++) begin
      issue(6'($urandom), 2'($urandom), 4'($urandom), $urandom, 4'($urandom),
            11'($urandom), -1, 1'b1);
      wait_done();
    end

    repeat (5) @(negedge clk);
    summary_and_end();
  end

endmodule
